product_selector_n: RTL and testbench

Parametrised successor to the fixed 3-product price selector. It supports NUM_PRODUCTS items, each with a per-product price table that software can write at run time and a per-product stock counter. Selection is held under an FSM with cancel and timeout. The block sits between the keypad decoder and the coin/payment module: it presents the held price, and it issues a one-cycle dispense pulse when payment completes.

---
 rtl/product_selector_n.sv | 195 +++++++++++++++++++
 tb/tb_product_selector_n.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/product_selector_n.sv
// Product selector for NUM_PRODUCTS items: a run-time writable price table, per-product
// stock counters, and an IDLE/HOLD/VEND selection FSM with cancel and timeout.
module product_selector_n #(
  parameter int NUM_PRODUCTS = 3,
  parameter int SEL_W        = 2,
  parameter int PRICE_W      = 5,
  parameter int BASE_PRICE   = 15,
  parameter int PRICE_STEP   = 5,
  parameter int STOCK_W      = 4,
  parameter int INIT_STOCK   = 5,
  parameter int TIMEOUT_CYC  = 100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SEL_W-1:0]   product_sel,
  input  logic               sel_valid,
  input  logic               cancel,
  input  logic               vend_done,
  input  logic               cfg_we,
  input  logic [SEL_W-1:0]   cfg_idx,
  input  logic [PRICE_W-1:0] cfg_price,
  input  logic               restock_valid,
  input  logic [SEL_W-1:0]   restock_idx,
  input  logic [STOCK_W-1:0] restock_qty,
  output logic [SEL_W-1:0]   selected_idx,
  output logic [PRICE_W-1:0] selected_price,
  output logic               sel_active,
  output logic               sold_out,
  output logic               timeout,
  output logic               dispense,
  output logic [SEL_W-1:0]   dispense_idx,
  output logic [STOCK_W-1:0] stock_level
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_VEND} state_t;

  localparam int                 CNT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [SEL_W-1:0]   MAX_IDX   = SEL_W'(NUM_PRODUCTS);
  localparam logic [STOCK_W:0]   STOCK_MAX = {1'b0, {STOCK_W{1'b1}}};
  localparam logic [STOCK_W:0]   STOCK_ONE = (STOCK_W + 1)'(1);

  state_t               state_reg, state_next;
  logic [SEL_W-1:0]     sel_idx_reg, sel_idx_next;
  logic [PRICE_W-1:0]   sel_price_reg, sel_price_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 sold_out_reg, sold_out_next;
  logic                 timeout_reg, timeout_next;

  logic [PRICE_W-1:0]   price_arr [NUM_PRODUCTS];
  logic [STOCK_W-1:0]   stock_arr [NUM_PRODUCTS];
  logic [PRICE_W-1:0]   lu_price;
  logic [STOCK_W-1:0]   lu_stock;
  logic                 sel_ok, in_stock;

  function automatic logic idx_ok(input logic [SEL_W-1:0] idx);
    return (idx != '0) && (idx <= MAX_IDX);
  endfunction

  // Per-product price and stock; a VEND decrement and a restock may land together.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PRODUCTS; gi++) begin : g_prod
      localparam logic [SEL_W-1:0] MY_IDX = SEL_W'(gi + 1);
      logic [PRICE_W-1:0] price_reg;
      logic [STOCK_W-1:0] stock_reg;
      logic [STOCK_W:0]   stock_sum;

      always_comb begin
        stock_sum = {1'b0, stock_reg};
        if (state_reg == S_VEND && sel_idx_reg == MY_IDX)
          stock_sum = stock_sum - STOCK_ONE;
        if (restock_valid && restock_idx == MY_IDX)
          stock_sum = stock_sum + {1'b0, restock_qty};
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          price_reg <= PRICE_W'(BASE_PRICE + gi * PRICE_STEP);
          stock_reg <= STOCK_W'(INIT_STOCK);
        end else begin
          if (cfg_we && cfg_idx == MY_IDX)
            price_reg <= cfg_price;
          stock_reg <= (stock_sum > STOCK_MAX) ? STOCK_MAX[STOCK_W-1:0] : stock_sum[STOCK_W-1:0];
        end
      end

      assign price_arr[gi] = price_reg;
      assign stock_arr[gi] = stock_reg;
    end
  endgenerate

  always_comb begin
    lu_price = '0;
    lu_stock = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (product_sel == SEL_W'(i + 1)) begin
        lu_price = price_arr[i];
        lu_stock = stock_arr[i];
      end
    end
  end

  assign sel_ok      = sel_valid && idx_ok(product_sel);
  assign in_stock    = (lu_stock != '0);
  assign stock_level = lu_stock;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      sel_idx_reg   <= '0;
      sel_price_reg <= '0;
      cnt_reg       <= '0;
      sold_out_reg  <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sel_idx_reg   <= sel_idx_next;
      sel_price_reg <= sel_price_next;
      cnt_reg       <= cnt_next;
      sold_out_reg  <= sold_out_next;
      timeout_reg   <= timeout_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sel_idx_next   = sel_idx_reg;
    sel_price_next = sel_price_reg;
    cnt_next       = cnt_reg;
    sold_out_next  = 1'b0;
    timeout_next   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (sel_ok) begin
          if (in_stock) begin
            state_next     = S_HOLD;
            sel_idx_next   = product_sel;
            sel_price_next = lu_price;
            cnt_next       = '0;
          end else begin
            sold_out_next = 1'b1;
          end
        end
      end
      S_HOLD: begin
        cnt_next = cnt_reg + CNT_ONE;
        if (vend_done) begin
          state_next = S_VEND;
        end else if (cancel) begin
          state_next     = S_IDLE;
          sel_idx_next   = '0;
          sel_price_next = '0;
        end else if (sel_ok && in_stock) begin
          sel_idx_next   = product_sel;
          sel_price_next = lu_price;
          cnt_next       = '0;
        end else begin
          // A sold-out request keeps the old selection and does not hold off the timeout.
          if (sel_ok)
            sold_out_next = 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_next     = S_IDLE;
            sel_idx_next   = '0;
            sel_price_next = '0;
            timeout_next   = 1'b1;
          end
        end
      end
      S_VEND: begin
        state_next     = S_IDLE;
        sel_idx_next   = '0;
        sel_price_next = '0;
      end
      default: begin
        state_next     = S_IDLE;
        sel_idx_next   = '0;
        sel_price_next = '0;
      end
    endcase
  end

  always_comb begin
    sel_active   = (state_reg == S_HOLD);
    dispense     = (state_reg == S_VEND);
    dispense_idx = (state_reg == S_VEND) ? sel_idx_reg : '0;
  end

  assign selected_idx   = sel_idx_reg;
  assign selected_price = sel_price_reg;
  assign sold_out       = sold_out_reg;
  assign timeout        = timeout_reg;

endmodule

// File: tb/tb_product_selector_n.sv
// Randomised and directed bench for product_selector_n; a behavioural model predicts every
// cycle's outputs and pulse events, and a monitor checks them against the DUT.
module tb_product_selector_n;

  localparam int N  = 3;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] product_sel = '0;
  logic       sel_valid = 1'b0, cancel = 1'b0, vend_done = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [4:0] cfg_price = '0;
  logic       restock_valid = 1'b0;
  logic [1:0] restock_idx = '0;
  logic [3:0] restock_qty = '0;
  logic [1:0] selected_idx, dispense_idx;
  logic [4:0] selected_price;
  logic       sel_active, sold_out, timeout, dispense;
  logic [3:0] stock_level;

  always #5 clk = ~clk;

  product_selector_n dut (
    .clk(clk), .reset(reset), .product_sel(product_sel), .sel_valid(sel_valid),
    .cancel(cancel), .vend_done(vend_done), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_price(cfg_price), .restock_valid(restock_valid), .restock_idx(restock_idx),
    .restock_qty(restock_qty), .selected_idx(selected_idx), .selected_price(selected_price),
    .sel_active(sel_active), .sold_out(sold_out), .timeout(timeout), .dispense(dispense),
    .dispense_idx(dispense_idx), .stock_level(stock_level)
  );

  typedef struct packed {
    logic [1:0] idx;
    logic [4:0] price;
    logic       act;
    logic       so;
    logic       to;
    logic       disp;
    logic [1:0] didx;
    logic [3:0] lvl;
  } snap_t;

  typedef struct {
    int kind;   // 1 sold_out, 2 timeout, 3 dispense
    int idx;
  } evt_t;

  snap_t snap_q[$];
  evt_t  evt_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cycle_no = 0;

  // Reference model: the machine's observable state in plain terms.
  int m_price [1:N];
  int m_stock [1:N];
  int m_held, m_hprice, m_age;
  bit m_vend;

  function automatic bit valid_idx(input int i);
    return (i >= 1) && (i <= N);
  endfunction

  task automatic model_reset();
    for (int i = 1; i <= N; i++) begin
      m_price[i] = (15 + (i - 1) * 5) % 32;
      m_stock[i] = 5;
    end
    m_held = 0; m_hprice = 0; m_age = 0; m_vend = 0;
  endtask

  task automatic model_step();
    bit    so = 0, to = 0, started_vend = 0;
    int    ps = int'(product_sel);
    bit    sok = sel_valid && valid_idx(ps);
    int    dec_idx = 0;
    snap_t s;
    evt_t  ev;
    if (reset) begin
      model_reset();
    end else begin
      if (m_vend) begin
        dec_idx = m_held; m_held = 0; m_vend = 0;
      end else if (m_held == 0) begin
        if (sok) begin
          if (m_stock[ps] > 0) begin m_held = ps; m_hprice = m_price[ps]; m_age = 0; end
          else so = 1;
        end
      end else begin
        if (vend_done) begin m_vend = 1; started_vend = 1; end
        else if (cancel) m_held = 0;
        else if (sok && m_stock[ps] > 0) begin m_held = ps; m_hprice = m_price[ps]; m_age = 0; end
        else begin
          if (sok) so = 1;
          if (m_age == TO - 1) begin m_held = 0; to = 1; end
          else m_age++;
        end
      end
      if (cfg_we && valid_idx(int'(cfg_idx))) m_price[int'(cfg_idx)] = int'(cfg_price);
      for (int i = 1; i <= N; i++) begin
        int v = m_stock[i];
        if (i == dec_idx) v = v - 1;
        if (restock_valid && int'(restock_idx) == i) v = v + int'(restock_qty);
        if (v > 15) v = 15;
        m_stock[i] = v;
      end
    end
    s.idx   = 2'(m_held);
    s.price = (m_held != 0) ? 5'(m_hprice) : 5'd0;
    s.act   = (m_held != 0) && !m_vend;
    s.so    = so;
    s.to    = to;
    s.disp  = m_vend;
    s.didx  = m_vend ? 2'(m_held) : 2'd0;
    s.lvl   = valid_idx(ps) ? 4'(m_stock[ps]) : 4'd0;
    snap_q.push_back(s);
    if (so) begin ev.kind = 1; ev.idx = 0; evt_q.push_back(ev); end
    if (to) begin ev.kind = 2; ev.idx = 0; evt_q.push_back(ev); end
    if (started_vend) begin ev.kind = 3; ev.idx = m_held; evt_q.push_back(ev); end
  endtask

  // Monitor: compare after each rising edge, independently of the stimulus.
  snap_t mon_exp, mon_act;

  task automatic check_evt(input int kind, input int idx);
    evt_t e;
    checks++;
    if (evt_q.size() == 0) begin
      failures++;
      $display("FAIL event cyc=%0d got kind=%0d idx=%0d, required no event", cycle_no, kind, idx);
    end else begin
      e = evt_q.pop_front();
      if (e.kind != kind || e.idx != idx) begin
        failures++;
        $display("FAIL event cyc=%0d got kind=%0d idx=%0d, required kind=%0d idx=%0d",
                 cycle_no, kind, idx, e.kind, e.idx);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    cycle_no++;
    if (snap_q.size() > 0) begin
      mon_exp = snap_q.pop_front();
      mon_act = {selected_idx, selected_price, sel_active, sold_out, timeout,
                 dispense, dispense_idx, stock_level};
      checks++;
      if (mon_act !== mon_exp) begin
        failures++;
        $display("FAIL outputs cyc=%0d got idx=%0d price=%0d act=%0b so=%0b to=%0b disp=%0b didx=%0d lvl=%0d, required idx=%0d price=%0d act=%0b so=%0b to=%0b disp=%0b didx=%0d lvl=%0d",
                 cycle_no, mon_act.idx, mon_act.price, mon_act.act, mon_act.so, mon_act.to,
                 mon_act.disp, mon_act.didx, mon_act.lvl, mon_exp.idx, mon_exp.price,
                 mon_exp.act, mon_exp.so, mon_exp.to, mon_exp.disp, mon_exp.didx, mon_exp.lvl);
      end
      if (sold_out === 1'b1) check_evt(1, 0);
      if (timeout === 1'b1)  check_evt(2, 0);
      if (dispense === 1'b1) check_evt(3, int'(dispense_idx));
    end
  end

  // Stimulus: set inputs after a falling edge, predict, then advance one cycle.
  task automatic cyc();
    model_step();
    @(negedge clk);
    sel_valid = 1'b0; cancel = 1'b0; vend_done = 1'b0; cfg_we = 1'b0; restock_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic sel(input int p);
    product_sel = 2'(p);
    sel_valid = 1'b1;
    cyc();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    cyc(); cyc();
    reset = 1'b0;
    cyc();

    // Default prices, each selection followed by cancel
    for (int p = 1; p <= 3; p++) begin
      sel(p); idle(1); cancel = 1'b1; cyc();
    end

    // Vend product 2
    sel(2); idle(1); vend_done = 1'b1; cyc(); idle(2);

    // Drain product 1, sold-out, restock, then select again
    for (int k = 0; k < 5; k++) begin
      sel(1); vend_done = 1'b1; cyc(); idle(1);
    end
    sel(1); idle(1);
    restock_valid = 1'b1; restock_idx = 2'd1; restock_qty = 4'd3; cyc();
    sel(1); idle(1); cancel = 1'b1; cyc();

    // Timeout, with a reselect at cycle 50 restarting the count
    sel(3); idle(49); sel(3); idle(TO + 3);

    // vend_done wins over cancel
    sel(3); vend_done = 1'b1; cancel = 1'b1; cyc(); idle(2);

    // Price rewrite while held
    sel(1); cfg_we = 1'b1; cfg_idx = 2'd1; cfg_price = 5'd30; cyc(); idle(2);
    cancel = 1'b1; cyc();
    sel(1); idle(1); cancel = 1'b1; cyc();

    // Asynchronous reset in the middle of HOLD
    sel(2); idle(1);
    reset = 1'b1;
    #1;
    checks++;
    if ({selected_idx, selected_price, sel_active, sold_out, timeout, dispense, dispense_idx} !== '0) begin
      failures++;
      $display("FAIL async_reset got idx=%0d price=%0d act=%0b so=%0b to=%0b disp=%0b didx=%0d, required all zero",
               selected_idx, selected_price, sel_active, sold_out, timeout, dispense, dispense_idx);
    end
    cyc();
    reset = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      sel(p); idle(1); cancel = 1'b1; cyc();
    end

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      sel_valid     = ($urandom_range(0, 99) < 25);
      product_sel   = 2'($urandom_range(0, 3));
      cancel        = ($urandom_range(0, 99) < 3);
      vend_done     = ($urandom_range(0, 99) < 6);
      cfg_we        = ($urandom_range(0, 99) < 4);
      cfg_idx       = 2'($urandom_range(0, 3));
      cfg_price     = 5'($urandom_range(0, 31));
      restock_valid = ($urandom_range(0, 99) < 4);
      restock_idx   = 2'($urandom_range(0, 3));
      restock_qty   = 4'($urandom_range(0, 15));
      cyc();
    end

    idle(3);
    @(posedge clk);
    #2;
    checks++;
    if (snap_q.size() != 0 || evt_q.size() != 0) begin
      failures++;
      $display("FAIL drain got snapshots=%0d events=%0d pending, required 0 and 0",
               snap_q.size(), evt_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
